// File: rtl/trivium_ks_xor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trivium_ks_xor_if : keystream, host data and result ports of trivium_ks_xor
// Rev 1.0
// ---------------------------------------------------------------------------
interface trivium_ks_xor_if #(
  parameter int W     = 32,
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] msg_words;
  logic             ks_bit;
  logic             ks_vld;
  logic             ks_rdy;
  logic [W-1:0]     din;
  logic             din_vld;
  logic             din_rdy;
  logic [W-1:0]     dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic             busy;
  logic             done;

  modport master (
    output start, msg_words, ks_bit, ks_vld, din, din_vld, dout_rdy,
    input  ks_rdy, din_rdy, dout, dout_vld, busy, done
  );

  modport slave (
    input  start, msg_words, ks_bit, ks_vld, din, din_vld, dout_rdy,
    output ks_rdy, din_rdy, dout, dout_vld, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/trivium_ks_xor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trivium_ks_xor : packs serial keystream into words and XORs them with host data
// Rev 1.0
// ---------------------------------------------------------------------------
module trivium_ks_xor #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  wire logic        CLK,
  input  wire logic        RSTn,
  trivium_ks_xor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(W);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_packed;
  logic [LEN_W-1:0] r_out_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [W-1:0]     r_shift;
  logic [W-1:0]     r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [W-1:0]     r_dout;
  logic             r_dout_vld;

  logic         w_full;
  logic         w_empty;
  logic         w_ks_rdy;
  logic         w_din_rdy;
  logic         w_busy;
  logic         w_done;
  logic         w_ks_acc;
  logic         w_push;
  logic         w_pop;
  logic         w_out_hs;
  logic         w_last_out;
  logic [W-1:0] w_push_word;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_ks_acc    = bus.ks_vld && w_ks_rdy;
  assign w_push      = w_ks_acc && (r_bit_cnt == BW'(W - 1));
  // Lower bits are already in the shifter; the final bit joins them on the fly.
  assign w_push_word = {bus.ks_bit, r_shift[W-2:0]};
  assign w_pop       = bus.din_vld && w_din_rdy;
  assign w_out_hs    = r_dout_vld && bus.dout_rdy;
  assign w_last_out  = w_out_hs && (r_out_cnt == r_len - LEN_W'(1));

  always_ff @(posedge CLK) begin
    if (!RSTn) r_state <= C_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE:  if (bus.start) w_next = (bus.msg_words != '0) ? C_RUN : C_DONE;
      C_RUN:   if (w_last_out) w_next = C_DONE;
      C_DONE:  w_next = C_IDLE;
      default: w_next = C_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == C_RUN);
    w_done    = (r_state == C_DONE);
    w_ks_rdy  = w_busy && !w_full && (r_packed < r_len);
    w_din_rdy = w_busy && !w_empty && (!r_dout_vld || bus.dout_rdy);
  end

  assign bus.ks_rdy   = w_ks_rdy;
  assign bus.din_rdy  = w_din_rdy;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_len      <= '0;
      r_packed   <= '0;
      r_out_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      if (r_state == C_IDLE && bus.start) begin
        r_len     <= bus.msg_words;
        r_packed  <= '0;
        r_out_cnt <= '0;
        r_bit_cnt <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
      end else begin
        if (w_ks_acc) begin
          r_shift[r_bit_cnt] <= bus.ks_bit;
          r_bit_cnt          <= r_bit_cnt + 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_packed <= r_packed + 1'b1;
        end
        if (w_pop)    r_rd_ptr  <= r_rd_ptr + 1'b1;
        if (w_out_hs) r_out_cnt <= r_out_cnt + 1'b1;
      end

      if (w_pop) begin
        r_dout     <= bus.din ^ r_mem[r_rd_ptr[AW-1:0]];
        r_dout_vld <= 1'b1;
      end else if (bus.dout_rdy) begin
        r_dout_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_word;
  end
endmodule
`default_nettype wire
